// File: rtl/mdom_trigger_gen2.sv
// mDOM waveform trigger (gen2): prioritised trigger sources, re-arm holdoff, 1-cycle aligned data.
// Optional accepted/vetoed counters are built only when MDOM_TRIG_COUNTERS_EN is defined.
module mdom_trigger_gen2 #(
    parameter int unsigned ADC_W     = 12,
    parameter int unsigned DISCR_W   = 8,
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [ADC_W-1:0]     adc_stream_in,
    output logic [ADC_W-1:0]     adc_stream_out,
    input  logic [DISCR_W-1:0]   discr_stream_in,
    output logic [DISCR_W-1:0]   discr_stream_out,
    input  logic                 gt,
    input  logic                 et,
    input  logic                 lt,
    input  logic [ADC_W-1:0]     thr,
    input  logic                 thresh_trig_en,
    input  logic                 thresh_edge,
    input  logic                 run,
    input  logic                 ext_trig_en,
    input  logic                 ext_run,
    input  logic                 cal_trig_en,
    input  logic                 cal_run,
    input  logic                 discr_trig_en,
    input  logic                 discr_trig_pol,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 trig,
    output logic [2:0]           trig_src,
    output logic                 thresh_tot,
    output logic                 discr_tot,
    output logic                 armed,
    output logic [31:0]          trig_cnt,
    output logic [31:0]          veto_cnt
);

    typedef enum logic {ST_ARMED = 1'b0, ST_HOLDOFF = 1'b1} state_t;

    localparam logic [2:0] SRC_NONE   = 3'd0;
    localparam logic [2:0] SRC_SW     = 3'd1;
    localparam logic [2:0] SRC_THRESH = 3'd2;
    localparam logic [2:0] SRC_EXT    = 3'd3;
    localparam logic [2:0] SRC_DISCR  = 3'd4;
    localparam logic [2:0] SRC_CAL    = 3'd5;

    state_t               state;
    logic [HOLDOFF_W-1:0] hold_cnt;
    logic                 run_q, ext_run_q, cal_run_q, cmp_q;
    logic                 cmp_c, discr_c, thr_req_c;
    logic [2:0]           src_c;
    logic                 any_req_c;

    // Source qualification and fixed-priority selection
    always_comb begin
        cmp_c = (gt && (adc_stream_in > thr)) ||
                (et && (adc_stream_in == thr)) ||
                (lt && (adc_stream_in < thr));
        discr_c   = discr_trig_pol ? (|discr_stream_in) : ~(&discr_stream_in);
        thr_req_c = thresh_trig_en && (thresh_edge ? (cmp_c && !cmp_q) : cmp_c);
        src_c     = SRC_NONE;
        if (ext_trig_en && ext_run && !ext_run_q) begin
            src_c = SRC_EXT;
        end else if (cal_trig_en && cal_run && !cal_run_q) begin
            src_c = SRC_CAL;
        end else if (discr_trig_en && discr_c) begin
            src_c = SRC_DISCR;
        end else if (thr_req_c) begin
            src_c = SRC_THRESH;
        end else if (run && !run_q) begin
            src_c = SRC_SW;
        end
        any_req_c = (src_c != SRC_NONE);
    end

    // Data alignment, edge history, and arm/holdoff state machine
    always_ff @(posedge clk) begin
        run_q     <= run;
        ext_run_q <= ext_run;
        cal_run_q <= cal_run;
        cmp_q     <= cmp_c;
        if (i_rst) begin
            adc_stream_out   <= '0;
            discr_stream_out <= '0;
            thresh_tot       <= 1'b0;
            discr_tot        <= 1'b0;
            trig             <= 1'b0;
            trig_src         <= SRC_NONE;
            armed            <= 1'b1;
            state            <= ST_ARMED;
            hold_cnt         <= '0;
        end else begin
            adc_stream_out   <= adc_stream_in;
            discr_stream_out <= discr_stream_in;
            thresh_tot       <= cmp_c;
            discr_tot        <= discr_c;
            trig             <= 1'b0;
            trig_src         <= SRC_NONE;
            case (state)
                ST_ARMED: begin
                    if (any_req_c) begin
                        trig     <= 1'b1;
                        trig_src <= src_c;
                        hold_cnt <= holdoff;
                        if (holdoff != '0) begin
                            state <= ST_HOLDOFF;
                            armed <= 1'b0;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    hold_cnt <= hold_cnt - HOLDOFF_W'(1);
                    if (hold_cnt == HOLDOFF_W'(1)) begin
                        state <= ST_ARMED;
                        armed <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef MDOM_TRIG_COUNTERS_EN
    // Accepted triggers and requests dropped while holding off
    always_ff @(posedge clk) begin
        if (i_rst) begin
            trig_cnt <= '0;
            veto_cnt <= '0;
        end else begin
            if ((state == ST_ARMED) && any_req_c) begin
                trig_cnt <= trig_cnt + 32'd1;
            end
            if ((state == ST_HOLDOFF) && any_req_c) begin
                veto_cnt <= veto_cnt + 32'd1;
            end
        end
    end
`else
    assign trig_cnt = '0;
    assign veto_cnt = '0;
`endif

endmodule

// File: tb/tb_mdom_trigger_gen2.sv
// Self-checking bench for mdom_trigger_gen2: directed scenarios plus random traffic vs a dead-time model.
module tb_mdom_trigger_gen2;

    localparam int unsigned ADC_W     = 12;
    localparam int unsigned DISCR_W   = 8;
    localparam int unsigned HOLDOFF_W = 16;

    logic                 clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic [ADC_W-1:0]     adc_stream_in = '0;
    logic [ADC_W-1:0]     adc_stream_out;
    logic [DISCR_W-1:0]   discr_stream_in = '1;
    logic [DISCR_W-1:0]   discr_stream_out;
    logic                 gt = 0, et = 0, lt = 0;
    logic [ADC_W-1:0]     thr = '0;
    logic                 thresh_trig_en = 0, thresh_edge = 0, run = 0;
    logic                 ext_trig_en = 0, ext_run = 0, cal_trig_en = 0, cal_run = 0;
    logic                 discr_trig_en = 0, discr_trig_pol = 0;
    logic [HOLDOFF_W-1:0] holdoff = '0;
    logic                 trig, thresh_tot, discr_tot, armed;
    logic [2:0]           trig_src;
    logic [31:0]          trig_cnt, veto_cnt;

    int checks = 0;
    int failures = 0;
    int seen_trig = 0;

    // Reference model state: remaining dead cycles and previous input levels
    int          m_dead = 0;
    bit          m_run = 0, m_ext = 0, m_cal = 0, m_c = 0;
    logic [31:0] m_tcnt = '0, m_vcnt = '0;

    mdom_trigger_gen2 #(.ADC_W(ADC_W), .DISCR_W(DISCR_W), .HOLDOFF_W(HOLDOFF_W)) dut (
        .clk(clk), .i_rst(i_rst),
        .adc_stream_in(adc_stream_in), .adc_stream_out(adc_stream_out),
        .discr_stream_in(discr_stream_in), .discr_stream_out(discr_stream_out),
        .gt(gt), .et(et), .lt(lt), .thr(thr),
        .thresh_trig_en(thresh_trig_en), .thresh_edge(thresh_edge), .run(run),
        .ext_trig_en(ext_trig_en), .ext_run(ext_run),
        .cal_trig_en(cal_trig_en), .cal_run(cal_run),
        .discr_trig_en(discr_trig_en), .discr_trig_pol(discr_trig_pol),
        .holdoff(holdoff), .trig(trig), .trig_src(trig_src),
        .thresh_tot(thresh_tot), .discr_tot(discr_tot), .armed(armed),
        .trig_cnt(trig_cnt), .veto_cnt(veto_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, clock, then compare every output
    task automatic step();
        bit c, d;
        int src;
        logic [ADC_W-1:0]   e_adc;
        logic [DISCR_W-1:0] e_discr;
        bit e_trig, e_ttot, e_dtot, e_armed;
        int e_src;
        c = (gt && (int'(adc_stream_in) > int'(thr))) ||
            (et && (int'(adc_stream_in) == int'(thr))) ||
            (lt && (int'(adc_stream_in) < int'(thr)));
        d = discr_trig_pol ? (int'(discr_stream_in) != 0) : (int'(discr_stream_in) != 255);
        e_trig = 0; e_src = 0;
        if (i_rst) begin
            m_dead = 0; m_tcnt = '0; m_vcnt = '0;
            e_adc = '0; e_discr = '0; e_ttot = 0; e_dtot = 0;
        end else begin
            src = 0;
            if (ext_trig_en && ext_run && !m_ext) src = 3;
            else if (cal_trig_en && cal_run && !m_cal) src = 5;
            else if (discr_trig_en && d) src = 4;
            else if (thresh_trig_en && (thresh_edge ? (c && !m_c) : c)) src = 2;
            else if (run && !m_run) src = 1;
            if (m_dead == 0) begin
                if (src != 0) begin
                    e_trig = 1; e_src = src; m_dead = int'(holdoff); m_tcnt = m_tcnt + 1;
                end
            end else begin
                if (src != 0) m_vcnt = m_vcnt + 1;
                m_dead = m_dead - 1;
            end
            e_adc = adc_stream_in; e_discr = discr_stream_in; e_ttot = c; e_dtot = d;
        end
        e_armed = (m_dead == 0);
        m_run = run; m_ext = ext_run; m_cal = cal_run; m_c = c;
        @(posedge clk);
        #1;
        if (trig === 1'b1) seen_trig++;
        chk("trig", 32'(trig), 32'(e_trig));
        chk("trig_src", 32'(trig_src), 32'(e_src));
        chk("adc_out", 32'(adc_stream_out), 32'(e_adc));
        chk("discr_out", 32'(discr_stream_out), 32'(e_discr));
        chk("thresh_tot", 32'(thresh_tot), 32'(e_ttot));
        chk("discr_tot", 32'(discr_tot), 32'(e_dtot));
        chk("armed", 32'(armed), 32'(e_armed));
`ifdef MDOM_TRIG_COUNTERS_EN
        chk("trig_cnt", trig_cnt, m_tcnt);
        chk("veto_cnt", veto_cnt, m_vcnt);
`else
        chk("trig_cnt", trig_cnt, 32'd0);
        chk("veto_cnt", veto_cnt, 32'd0);
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset
        i_rst = 1; steps(2); i_rst = 0; step();

        // Level threshold ramp 98..103
        thr = 12'd100; gt = 1; thresh_trig_en = 1; seen_trig = 0;
        for (int v = 98; v <= 103; v++) begin
            adc_stream_in = ADC_W'(v);
            step();
            if (v == 101) chk("ramp_first_adc", 32'(adc_stream_out), 32'd101);
        end
        adc_stream_in = '0; step();
        chk("ramp_level_trigs", 32'(seen_trig), 32'd3);

        // Edge mode: one trig per comparator rise
        thresh_edge = 1; seen_trig = 0;
        for (int v = 98; v <= 103; v++) begin adc_stream_in = ADC_W'(v); step(); end
        adc_stream_in = 12'd50; step();
        adc_stream_in = 12'd120; step(); step();
        chk("edge_trigs", 32'(seen_trig), 32'd2);
        thresh_trig_en = 0; thresh_edge = 0; gt = 0; adc_stream_in = '0; step();

        // Simultaneous ext/cal/discr: ext wins, then discr
        ext_trig_en = 1; cal_trig_en = 1; discr_trig_en = 1; discr_stream_in = 8'h00;
        ext_run = 1; cal_run = 1; step();
        chk("prio_ext", 32'(trig_src), 32'd3);
        step();
        chk("prio_discr_next", 32'(trig_src), 32'd4);
        ext_run = 0; cal_run = 0; ext_trig_en = 0; cal_trig_en = 0;

        // Holdoff 5 with discr held active
        holdoff = 16'd5; seen_trig = 0;
        steps(18);
        chk("holdoff_period_trigs", 32'(seen_trig), 32'd3);
        discr_trig_en = 0; discr_stream_in = '1; steps(6);
        holdoff = '0;

        // Run high through reset release
        run = 1; i_rst = 1; steps(2); i_rst = 0; seen_trig = 0; steps(3);
        chk("run_held_no_trig", 32'(seen_trig), 32'd0);
        run = 0; step(); run = 1; step();
        chk("sw_trig_src", 32'(trig_src), 32'd1);
        run = 0; step();

        // Reset aborts a long holdoff
        holdoff = 16'd1000; discr_trig_en = 1; discr_stream_in = 8'h0F; step();
        steps(2);
        i_rst = 1; step(); i_rst = 0;
        chk("rst_abort_armed", 32'(armed), 32'd1);
        chk("rst_abort_trig_cnt", trig_cnt, 32'd0);
        step();
        chk("rst_abort_retrig", 32'(trig), 32'd1);
        discr_trig_en = 0; discr_stream_in = '1;
        i_rst = 1; step(); i_rst = 0;

        // Random traffic near threshold
        thr = 12'd100;
        for (int i = 0; i < 400; i++) begin
            adc_stream_in   = ADC_W'($urandom_range(96, 104));
            discr_stream_in = ($urandom_range(0, 3) == 0) ? DISCR_W'($urandom) : '1;
            gt = 1'($urandom); et = 1'($urandom); lt = 1'($urandom);
            thresh_trig_en = ($urandom_range(0, 3) == 0);
            thresh_edge    = 1'($urandom);
            run            = 1'($urandom);
            ext_trig_en    = 1'($urandom); ext_run = 1'($urandom);
            cal_trig_en    = 1'($urandom); cal_run = 1'($urandom);
            discr_trig_en  = ($urandom_range(0, 3) == 0);
            discr_trig_pol = 1'($urandom);
            holdoff        = HOLDOFF_W'($urandom_range(0, 6));
            i_rst          = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
